// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t   : responder FSM states (IDLE / WAIT / RESP)
//   CNT_W     : width of the latency wait counter (LATENCY range 0..15)
//   be_width  : number of byte-enable bits for a W-bit data word
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    function automatic int be_width(input int w);
        return w / 8;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables.
//   clk   : write clock
//   we    : write strobe, one word written on the rising edge
//   be    : byte enables, only bytes with a 1 are updated
//   idx   : word index shared by the write and read paths
//   wdata : write data
//   rdata : combinational read of word idx
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int    W         = 32,
  parameter int    datawords = 1024,
  parameter string DFILE     = ""
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [be_width(W)-1:0]       be,
  input  logic [$clog2(datawords)-1:0] idx,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata
);

  logic [W-1:0] mem [datawords];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < be_width(W); b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed response latency.
//   clk, rst                : clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_we/addr/wdata/be    : request fields, latched on accept
//   rsp_valid/rsp_ready     : response handshake (valid only in RESP)
//   rsp_rdata, rsp_err      : load data (0 for stores/errors) and error flag
//   dbg_state               : current FSM state for observation
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1; the producer holds its payload until then, and each side may
// drive valid/ready independently of the other side's signal.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int    W         = 32,
    parameter int    datawords = 1024,
    parameter int    LATENCY   = 2,
    parameter string DFILE     = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [W-1:0]           req_addr,
    input  logic [W-1:0]           req_wdata,
    input  logic [be_width(W)-1:0] req_be,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [W-1:0]           rsp_rdata,
    output logic                   rsp_err,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = $clog2(datawords);
    // One past the last valid byte address, one bit wider than the address.
    localparam logic [W:0] LIMIT = (W+1)'(datawords) << 2;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;

    logic                   lat_we;
    logic [W-1:0]           lat_addr;
    logic [W-1:0]           lat_wdata;
    logic [be_width(W)-1:0] lat_be;

    logic                   acc_we;
    logic [W-1:0]           acc_addr;
    logic [W-1:0]           acc_wdata;
    logic [be_width(W)-1:0] acc_be;
    logic                   acc_err;
    logic                   enter_resp;
    logic                   mem_we;
    logic [W-1:0]           mem_rdata;

    // With LATENCY=0 the access commits on the accept edge itself, before the
    // latches hold the request, so the live request fields are used in IDLE.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
    end

    assign acc_err    = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= LIMIT);
    assign enter_resp = (state_nx == RESP) && (state != RESP);
    // Gated by rst so a reset on the would-be commit edge writes nothing.
    assign mem_we     = rst && enter_resp && acc_we && !acc_err;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            // Response registers are loaded once and held for the whole RESP.
            if (enter_resp) begin
                rsp_rdata <= (acc_we || acc_err) ? '0 : mem_rdata;
                rsp_err   <= acc_err;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign dbg_state = state;

    dmem_array #(
        .W         (W),
        .datawords (datawords),
        .DFILE     (DFILE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (acc_be),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder. Two instances share the
// request bus: dut_a uses LATENCY=2, dut_b uses LATENCY=0; sel picks which one
// the driver and monitor talk to.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int LAT_A = 2;
    localparam int NW    = 64;      // low words exercised by random traffic
    localparam int DW    = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT wiring ----------------
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;
    logic [1:0]  dbg_a, dbg_b;

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;
    assign m_req_ready = sel ? req_ready_b : req_ready_a;
    assign m_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign m_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
    assign m_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;

    dmem_responder #(.W(32), .datawords(DW), .LATENCY(LAT_A), .DFILE("")) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(req_ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .dbg_state(dbg_a)
    );

    dmem_responder #(.W(32), .datawords(DW), .LATENCY(0), .DFILE("")) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(req_ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .dbg_state(dbg_b)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          acc_q[$];
    logic [31:0] mdl [2][DW];   // reference memory per instance

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: aligned, in-range accesses read or byte-merge a word.
    task automatic predict(input logic s, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input bit commit,
                           output logic [31:0] er, output logic ee);
        int w;
        ee = (addr % 4 != 0) || (addr >= 32'(DW * 4));
        er = '0;
        if (!ee) begin
            w = int'(addr / 4);
            if (we) begin
                if (commit)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mdl[s][w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                er = mdl[s][w];
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int stall, input bit abort);
        logic [31:0] er;
        logic        ee;
        int          n;
        logic        rdy;
        predict(sel, we, addr, wdata, be, !abort, er, ee);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        n = 0; rdy = 1'b0;
        while (!rdy && n < 40) begin
            @(negedge clk); rdy = m_req_ready;
            @(posedge clk); #1; n++;
        end
        if (!rdy) begin
            check("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
        end
        if (abort) begin
            // Reset lands while the store is still waiting.
            req_valid = 1'b0;
            rst = 1'b0;
            @(posedge clk); #1;
            check("abort_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
            check("abort_req_ready", {31'b0, req_ready_a}, 32'd1);
            check("abort_state", {30'b0, dbg_a}, {30'b0, IDLE});
            rst = 1'b1;
            return;
        end
        acc_q.push_back(cyc - 1);
        exp_q.push_back(er);
        exp_err_q.push_back(ee);
        // Noise on the request bus while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_we = 1'($urandom_range(0, 1)); req_addr = $urandom(); req_wdata = $urandom();
        req_be = 4'($urandom_range(0, 15));
        n = 0;
        @(negedge clk);
        while (!m_rsp_valid && n < 40) begin @(negedge clk); n++; end
        if (!m_rsp_valid) begin
            check("response_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
        end
        repeat (stall) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("req_ready_after_hs", {31'b0, m_req_ready}, 32'd1);
        check("rsp_valid_after_hs", {31'b0, m_rsp_valid}, 32'd0);
    endtask

    // ---------------- monitor ----------------
    logic        in_rsp = 1'b0;
    logic [31:0] cur_d = '0;
    logic        cur_e = 1'b0;
    int          cur_acc = 0;
    always @(negedge clk) begin
        if (rst && m_rsp_valid) begin
            if (!in_rsp) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 32'd1, 32'd0);
                end else begin
                    cur_d   = exp_q.pop_front();
                    cur_e   = exp_err_q.pop_front();
                    cur_acc = acc_q.pop_front();
                    check("rsp_rdata", m_rsp_rdata, cur_d);
                    check("rsp_err", {31'b0, m_rsp_err}, {31'b0, cur_e});
                    check("rsp_latency", 32'(cyc - cur_acc), sel ? 32'd1 : 32'(LAT_A + 1));
                end
                in_rsp = 1'b1;
            end else begin
                check("rsp_rdata_stable", m_rsp_rdata, cur_d);
                check("rsp_err_stable", {31'b0, m_rsp_err}, {31'b0, cur_e});
            end
            check("req_ready_in_resp", {31'b0, m_req_ready}, 32'd0);
        end else begin
            in_rsp = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          r;

        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {31'b0, req_ready_a}, 32'd1);
        check("reset_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata_a, 32'd0);
        check("reset_rsp_err", {31'b0, rsp_err_a}, 32'd0);
        check("reset_state_a", {30'b0, dbg_a}, {30'b0, IDLE});
        check("reset_state_b", {30'b0, dbg_b}, {30'b0, IDLE});
        rst = 1'b1;

        // Give every word the traffic touches a known value.
        sel = 1'b0;
        for (int i = 0; i < NW; i++) issue(1'b1, 32'(i * 4), $urandom(), 4'hF, 0, 1'b0);
        issue(1'b1, 32'(DW * 4 - 4), $urandom(), 4'hF, 0, 1'b0);

        // Basic store/load at LATENCY=2.
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
        // Single-byte merge.
        issue(1'b1, 32'h14, 32'h1122_3344, 4'hF, 1, 1'b0);
        issue(1'b1, 32'h14, 32'h0000_00AA, 4'h1, 0, 1'b0);
        issue(1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b0);
        // Errors: misaligned load, out-of-range store aliasing word 0.
        issue(1'b0, 32'h2, 32'h0, 4'h0, 0, 1'b0);
        issue(1'b1, 32'd4096, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
        // Long back-pressure on a response.
        issue(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0);
        // Reset during WAIT of a store, then the old value must remain.
        issue(1'b1, 32'h20, 32'h5555_AAAA, 4'hF, 0, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      a = 32'($urandom_range(0, NW - 1) * 4);
            else if (r == 7) a = 32'($urandom_range(0, NW - 1) * 4 + $urandom_range(1, 3));
            else if (r == 8) a = ($urandom() | 32'h0000_1000) & ~32'h3;
            else             a = 32'(DW * 4 - 4);
            issue(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), 1'b0);
        end

        // LATENCY=0 instance: store then load the same word.
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom_range(0, NW - 1) * 4);
            issue(1'b1, a, $urandom(), 4'hF, $urandom_range(0, 2), 1'b0);
            issue(1'b1, a, $urandom(), 4'($urandom_range(0, 15)), 0, 1'b0);
            issue(1'b0, a, 32'h0, 4'h0, 0, 1'b0);
        end
        sel = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter W, default 32, data and address width in bits.
REQ-002 Parameter datawords, default 1024, number of W-bit storage words.
REQ-003 Parameter LATENCY, default 2, wait cycles between request acceptance and response (0..15).
REQ-004 Parameter DFILE, default "", hex preload file; empty string means no preload.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  1  core presents a memory request.
REQ-008 req_ready  output  1  responder can accept a request.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 req_addr  input  W  byte address.
REQ-011 req_wdata  input  W  store data.
REQ-012 req_be  input  W/8  byte enables for stores; ignored for loads.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  core consumes the response.
REQ-015 rsp_rdata  output  W  load data; 0 for stores and errors.
REQ-016 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-019 A request SHALL be accepted when req_valid and req_ready are both high at a clock edge; we, addr, wdata and be SHALL be latched.
REQ-020 On accept, if LATENCY=0 the FSM SHALL go to RESP; otherwise it SHALL go to WAIT with the counter loaded with LATENCY-1.
REQ-021 In WAIT, the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to RESP on the next edge; LATENCY=N gives rsp_valid exactly N+1 cycles after accept.
REQ-022 The memory access SHALL commit on the edge entering RESP; a store SHALL update only the bytes whose be bit is 1.
REQ-023 Word index SHALL be addr[log2(datawords)+1:2].
REQ-024 Error condition: addr[1:0] != 0, or addr >= datawords*4. On error: no write, rsp_rdata=0, rsp_err=1.
REQ-025 rsp_rdata and rsp_err SHALL stay stable while in RESP.
REQ-026 RESP SHALL hold until rsp_ready=1, then go to IDLE; req_ready SHALL rise the cycle after the handshake, giving no same-cycle back-to-back accept.
REQ-027 A load to the same address as the preceding store SHALL return the stored data (the commit is complete before the next accept).
REQ-028 req_valid SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RESP.

Reset
REQ-029 While rst=0 at an edge: state=IDLE, counter=0, req_ready=1 after the edge, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-030 Reset during WAIT SHALL abort the request with no memory write; reset during RESP SHALL drop the response.
REQ-031 Storage contents SHALL NOT be cleared by reset; DFILE preload applies at time 0 only.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/WAIT/RESP), the counter width constant (4) and the byte-enable width derivation.
REQ-033 Storage SHALL be the sub-module dmem_array: synchronous byte-enable write, combinational read, parameters W, datawords and DFILE.

Verification
REQ-034 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 0xF, then load 0x10 -> rsp_valid 3 cycles after each accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 Store 0x000000AA with be 0x1 to a word holding 0x11223344, then load -> 0x112233AA.
REQ-036 Load addr 0x2 -> rsp_err=1, rsp_rdata=0; store to addr 4096 with datawords=1024 -> rsp_err=1, memory unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; after rsp_ready=1, req_ready=1 the next cycle.
REQ-038 Assert rst=0 during WAIT of a store to 0x20 -> IDLE next cycle, rsp_valid=0; a later load of 0x20 returns the old value.
REQ-039 LATENCY=0: load accepted -> rsp_valid on the very next cycle.
